// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pipe_ctrl_if : hazard/handshake inputs from the datapath and the        |
// |                pipeline-register controls returned by pipe_ctrl         |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rw;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rw;
  logic             mem_reg_write;
  logic [4:0]       wb_rw;
  logic             wb_reg_write;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_err;

  // Datapath side
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_rs, ex_rt, ex_rw, ex_reg_write, ex_mem_read,
    output mem_rw, mem_reg_write, wb_rw, wb_reg_write,
    output branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt, mem_err
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_rs, ex_rt, ex_rw, ex_reg_write, ex_mem_read,
    input  mem_rw, mem_reg_write, wb_rw, wb_reg_write,
    input  branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush,
    output fwd_a, fwd_b, stall_cnt, flush_cnt, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pipe_ctrl : 5-stage pipeline sequencing (stall/flush/freeze, forwarding,|
// |             stall/flush counters, memory-wait timeout)                  |
// | Option    : define PIPE_CTRL_FWD_EN for operand forwarding              |
// | Revision  : 1.0                                                         |
// +-------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]       WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       wait_cnt;
  logic [7:0]       wait_cnt_nxt;
  logic             mem_err;
  logic             mem_err_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             freeze;
  logic             hazard;
  logic             do_flush;
  logic             do_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // A source only matters when it is read, the producer writes, and it is not r0.
  function automatic logic src_hit(input logic       use_src,
                                   input logic [4:0] src,
                                   input logic       wr,
                                   input logic [4:0] dst);
    return use_src & wr & (dst != 5'd0) & (src == dst);
  endfunction

  assign freeze = bus.mem_req & ~bus.mem_ready;

`ifdef PIPE_CTRL_FWD_EN
  assign hazard = bus.ex_mem_read &
                  (src_hit(bus.id_use_rs, bus.id_rs, bus.ex_reg_write, bus.ex_rw) |
                   src_hit(bus.id_use_rt, bus.id_rt, bus.ex_reg_write, bus.ex_rw));

  assign fwd_a = src_hit(1'b1, bus.ex_rs, bus.mem_reg_write, bus.mem_rw) ? 2'b01 :
                 src_hit(1'b1, bus.ex_rs, bus.wb_reg_write,  bus.wb_rw)  ? 2'b10 : 2'b00;
  assign fwd_b = src_hit(1'b1, bus.ex_rt, bus.mem_reg_write, bus.mem_rw) ? 2'b01 :
                 src_hit(1'b1, bus.ex_rt, bus.wb_reg_write,  bus.wb_rw)  ? 2'b10 : 2'b00;
`else
  // Without forwarding, ID waits until its producer reaches WB (regfile write-then-read).
  assign hazard = src_hit(bus.id_use_rs, bus.id_rs, bus.ex_reg_write,  bus.ex_rw)  |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.ex_reg_write,  bus.ex_rw)  |
                  src_hit(bus.id_use_rs, bus.id_rs, bus.mem_reg_write, bus.mem_rw) |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.mem_reg_write, bus.mem_rw);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // Priority: freeze > flush > stall > normal; reset forces the idle pattern.
  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.idex_en     = 1'b1;
    bus.exmem_en    = 1'b1;
    bus.memwb_en    = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.memwb_flush = 1'b0;
    bus.fwd_a       = 2'b00;
    bus.fwd_b       = 2'b00;
    do_flush        = 1'b0;
    do_stall        = 1'b0;
    if (rst_n) begin
      bus.fwd_a = fwd_a;
      bus.fwd_b = fwd_b;
      if (freeze) begin
        bus.pc_en       = 1'b0;
        bus.ifid_en     = 1'b0;
        bus.idex_en     = 1'b0;
        bus.exmem_en    = 1'b0;
        bus.memwb_flush = 1'b1;
      end else if (bus.branch_taken) begin
        do_flush       = 1'b1;
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end else if (hazard) begin
        do_stall       = 1'b1;
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_nxt = RUN;
        end else begin
          if (wait_cnt != 8'hFF) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
          if (wait_cnt_nxt == WAIT_LIM) begin
            mem_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
      if ((freeze | do_stall) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (do_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
  assign bus.mem_err   = mem_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// tb_pipe_ctrl: directed vectors with a queued expected-response scoreboard.
module tb_pipe_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef enum int {C_NORM, C_STALL, C_FLUSH, C_FREEZE, C_RST} cls_t;

`ifdef PIPE_CTRL_FWD_EN
  localparam cls_t ALU_DEP = C_NORM;
`else
  localparam cls_t ALU_DEP = C_STALL;
`endif

  typedef struct packed {
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rw;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] mem_rw;
    logic       mem_reg_write;
    logic [4:0] wb_rw;
    logic       wb_reg_write;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
  } vec_t;

  typedef struct {
    int unsigned      id;
    logic [4:0]       en;
    logic [2:0]       fl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipe_ctrl #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          tests       = 0;
  int          failed      = 0;
  int unsigned vec_id      = 0;
  int          stall_tally = 0;
  int          flush_tally = 0;

  function automatic vec_t idle();
    vec_t v;
    v       = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n             = v.rst_n;
    bus.id_rs         = v.id_rs;
    bus.id_rt         = v.id_rt;
    bus.id_use_rs     = v.id_use_rs;
    bus.id_use_rt     = v.id_use_rt;
    bus.ex_rs         = v.ex_rs;
    bus.ex_rt         = v.ex_rt;
    bus.ex_rw         = v.ex_rw;
    bus.ex_reg_write  = v.ex_reg_write;
    bus.ex_mem_read   = v.ex_mem_read;
    bus.mem_rw        = v.mem_rw;
    bus.mem_reg_write = v.mem_reg_write;
    bus.wb_rw         = v.wb_rw;
    bus.wb_reg_write  = v.wb_reg_write;
    bus.branch_taken  = v.branch_taken;
    bus.mem_req       = v.mem_req;
    bus.mem_ready     = v.mem_ready;
  endtask

  // fa/fb are the forwarding-build selects; the plain build always expects 00.
  task automatic drive(input vec_t v, input cls_t cls, input logic [1:0] fa,
                       input logic [1:0] fb, input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    apply(v);
    vec_id++;
    if (cls == C_RST) begin
      stall_tally = 0;
      flush_tally = 0;
    end
    e.id = vec_id;
    case (cls)
      C_STALL:  begin e.en = 5'b00111; e.fl = 3'b010; end
      C_FLUSH:  begin e.en = 5'b11111; e.fl = 3'b110; end
      C_FREEZE: begin e.en = 5'b00001; e.fl = 3'b001; end
      default:  begin e.en = 5'b11111; e.fl = 3'b000; end
    endcase
`ifdef PIPE_CTRL_FWD_EN
    e.fa = (cls == C_RST) ? 2'b00 : fa;
    e.fb = (cls == C_RST) ? 2'b00 : fb;
`else
    e.fa = 2'b00;
    e.fb = 2'b00;
`endif
    e.sc  = CNT_W'(stall_tally);
    e.fc  = CNT_W'(flush_tally);
    e.err = err;
    exp_q.push_back(e);
    if ((cls == C_STALL || cls == C_FREEZE) && stall_tally < CNT_MAX) stall_tally++;
    if (cls == C_FLUSH && flush_tally < CNT_MAX) flush_tally++;
  endtask

  task automatic chk(input string name, input int unsigned id,
                     input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL vec %0d %s: got %0h, expected %0h", id, name, act, req);
    end
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
  endtask

  // Monitor: every cycle carries a full output set, compared mid-cycle.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        chk("enables", m.id, 16'({bus.pc_en, bus.ifid_en, bus.idex_en,
                                  bus.exmem_en, bus.memwb_en}), 16'(m.en));
        chk("flushes", m.id, 16'({bus.ifid_flush, bus.idex_flush, bus.memwb_flush}),
            16'(m.fl));
        chk("fwd_a",     m.id, 16'(bus.fwd_a),     16'(m.fa));
        chk("fwd_b",     m.id, 16'(bus.fwd_b),     16'(m.fb));
        chk("stall_cnt", m.id, 16'(bus.stall_cnt), 16'(m.sc));
        chk("flush_cnt", m.id, 16'(bus.flush_cnt), 16'(m.fc));
        chk("mem_err",   m.id, 16'(bus.mem_err),   16'(m.err));
      end
    end
  end

  initial begin
    #100000;
    failed++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    v       = idle();
    v.rst_n = 1'b0;
    apply(v);

    // Reset with freeze/branch/forward conditions present: outputs forced idle.
    v = idle(); v.rst_n = 1'b0; v.mem_req = 1'b1; v.branch_taken = 1'b1;
    v.mem_rw = 5'd7; v.mem_reg_write = 1'b1; v.ex_rs = 5'd7;
    drive(v, C_RST, 2'b00, 2'b00, 1'b0);
    v = idle();
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    // Load-use on rs, then the load sits in MEM.
    v = idle(); v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1; v.ex_rw = 5'd5;
    v.id_rs = 5'd5; v.id_use_rs = 1'b1;
    drive(v, C_STALL, 2'b00, 2'b00, 1'b0);
    v = idle(); v.mem_rw = 5'd5; v.mem_reg_write = 1'b1; v.ex_rs = 5'd5;
    drive(v, C_NORM, 2'b01, 2'b00, 1'b0);

    // Load-use on rt.
    v = idle(); v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1; v.ex_rw = 5'd12;
    v.id_rs = 5'd12; v.id_rt = 5'd12; v.id_use_rt = 1'b1;
    drive(v, C_STALL, 2'b00, 2'b00, 1'b0);

    // Forwarding priority and selection.
    v = idle(); v.mem_rw = 5'd7; v.mem_reg_write = 1'b1; v.wb_rw = 5'd7;
    v.wb_reg_write = 1'b1; v.ex_rs = 5'd7; v.ex_rt = 5'd7;
    drive(v, C_NORM, 2'b01, 2'b01, 1'b0);
    v = idle(); v.mem_rw = 5'd7; v.mem_reg_write = 1'b1; v.ex_rs = 5'd0;
    v.ex_rt = 5'd9; v.wb_rw = 5'd9; v.wb_reg_write = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b10, 1'b0);
    v = idle(); v.mem_rw = 5'd7; v.ex_rs = 5'd7; v.wb_rw = 5'd7; v.wb_reg_write = 1'b1;
    drive(v, C_NORM, 2'b10, 2'b00, 1'b0);
    v = idle(); v.mem_rw = 5'd0; v.mem_reg_write = 1'b1; v.wb_rw = 5'd0;
    v.wb_reg_write = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    // Non-hazards: unused sources, r0 destination, non-writing load.
    v = idle(); v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1; v.ex_rw = 5'd6;
    v.id_rs = 5'd6; v.id_rt = 5'd6;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);
    v = idle(); v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1; v.ex_rw = 5'd0;
    v.id_rs = 5'd0; v.id_use_rs = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);
    v = idle(); v.ex_mem_read = 1'b1; v.ex_rw = 5'd5; v.id_rs = 5'd5; v.id_use_rs = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    // Dependent ALU pair: producer in EXE, then MEM, then WB.
    v = idle(); v.ex_reg_write = 1'b1; v.ex_rw = 5'd3; v.id_rt = 5'd3; v.id_use_rt = 1'b1;
    drive(v, ALU_DEP, 2'b00, 2'b00, 1'b0);
    v = idle(); v.mem_rw = 5'd3; v.mem_reg_write = 1'b1; v.id_rt = 5'd3; v.id_use_rt = 1'b1;
    drive(v, ALU_DEP, 2'b00, 2'b00, 1'b0);
    v = idle(); v.wb_rw = 5'd3; v.wb_reg_write = 1'b1; v.id_rt = 5'd3; v.id_use_rt = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    // Branch, branch over load-use, branch held by freeze.
    v = idle(); v.branch_taken = 1'b1;
    drive(v, C_FLUSH, 2'b00, 2'b00, 1'b0);
    v = idle(); v.branch_taken = 1'b1; v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1;
    v.ex_rw = 5'd5; v.id_rs = 5'd5; v.id_use_rs = 1'b1;
    drive(v, C_FLUSH, 2'b00, 2'b00, 1'b0);
    v = idle(); v.branch_taken = 1'b1; v.mem_req = 1'b1;
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    v = idle(); v.branch_taken = 1'b1; v.mem_req = 1'b1; v.mem_ready = 1'b1;
    drive(v, C_FLUSH, 2'b00, 2'b00, 1'b0);

    // Three-cycle memory wait (first one also carries a hazard).
    v = idle(); v.mem_req = 1'b1; v.ex_mem_read = 1'b1; v.ex_reg_write = 1'b1;
    v.ex_rw = 5'd5; v.id_rs = 5'd5; v.id_use_rs = 1'b1;
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    v = idle(); v.mem_req = 1'b1;
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    v.mem_ready = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);
    v = idle();
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    // Flush counter saturation.
    v = idle(); v.branch_taken = 1'b1;
    for (int i = 0; i < 16; i++) drive(v, C_FLUSH, 2'b00, 2'b00, 1'b0);

    // Timeout: entry cycle plus WAIT_MAX frozen MEM_WAIT cycles before mem_err shows.
    v = idle(); v.mem_req = 1'b1;
    for (int k = 0; k < 20; k++) drive(v, C_FREEZE, 2'b00, 2'b00, (k >= WAIT_MAX + 1));
    v.mem_ready = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b1);
    v = idle();
    drive(v, C_NORM, 2'b00, 2'b00, 1'b1);

    // Asynchronous reset mid-wait, then a still-pending request after release.
    v = idle(); v.rst_n = 1'b0; v.mem_req = 1'b1;
    drive(v, C_RST, 2'b00, 2'b00, 1'b0);
    v = idle(); v.mem_req = 1'b1;
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    drive(v, C_FREEZE, 2'b00, 2'b00, 1'b0);
    v.mem_ready = 1'b1;
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);
    v = idle();
    drive(v, C_NORM, 2'b00, 2'b00, 1'b0);

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    summary();
    $finish;
  end

endmodule
`default_nettype wire
